// File: rtl/md_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_issue_ctrl_pkg
//  Description : Shared HILO op codes, default latencies and state encoding
//                for the E-stage multiply/divide issue controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package md_issue_ctrl_pkg;

  // Op-code width of the HILO interface.
  localparam int c_HILO_OP_W = 4;

  // HILO op codes, shared with the HILO unit and the decoder.
  localparam logic [c_HILO_OP_W-1:0] c_HILO_NONE  = 4'd0;
  localparam logic [c_HILO_OP_W-1:0] c_HILO_MULT  = 4'd1;
  localparam logic [c_HILO_OP_W-1:0] c_HILO_MULTU = 4'd2;
  localparam logic [c_HILO_OP_W-1:0] c_HILO_DIV   = 4'd3;
  localparam logic [c_HILO_OP_W-1:0] c_HILO_DIVU  = 4'd4;
  localparam logic [c_HILO_OP_W-1:0] c_HILO_MFHI  = 4'd5;
  localparam logic [c_HILO_OP_W-1:0] c_HILO_MFLO  = 4'd6;
  localparam logic [c_HILO_OP_W-1:0] c_HILO_MTHI  = 4'd7;
  localparam logic [c_HILO_OP_W-1:0] c_HILO_MTLO  = 4'd8;

  // Default unit latencies: issue edge to HI/LO write edge.
  localparam int c_MULT_LAT_DEF = 5;
  localparam int c_DIV_LAT_DEF  = 10;

  // Issue controller state: IDLE (unit free) or RUN (operation in flight).
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage : md_issue_ctrl_pkg
`default_nettype wire

// File: rtl/md_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : md_issue_ctrl_if
//  Description : E-stage md handshake bundle between the pipeline, the
//                issue controller and the HILO unit.
//                master : issue controller side
//                slave  : pipeline / HILO unit side
//  Revision    : 1.0 - initial release
// ============================================================================
interface md_issue_ctrl_if #(
  parameter int OP_W  = 4,
  parameter int CNT_W = 4
);

  // Pipeline to controller
  logic             Req;
  logic             E_Valid;
  logic [OP_W-1:0]  E_MdOp;
  logic [31:0]      E_RsVal;
  logic [31:0]      E_RtVal;

  // HILO unit to controller
  logic             Mdu_Busy;

  // Controller to HILO unit
  logic [OP_W-1:0]  Mdu_Op;
  logic [31:0]      Mdu_D1;
  logic [31:0]      Mdu_D2;

  // Controller to pipeline / status
  logic             Stall_E;
  logic             Pending;
  logic [CNT_W-1:0] Remain;
  logic             Err;

  modport master (
    input  Req, E_Valid, E_MdOp, E_RsVal, E_RtVal, Mdu_Busy,
    output Mdu_Op, Mdu_D1, Mdu_D2, Stall_E, Pending, Remain, Err
  );

  modport slave (
    output Req, E_Valid, E_MdOp, E_RsVal, E_RtVal, Mdu_Busy,
    input  Mdu_Op, Mdu_D1, Mdu_D2, Stall_E, Pending, Remain, Err
  );

endinterface : md_issue_ctrl_if
`default_nettype wire

// File: rtl/md_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : md_issue_ctrl
//  Description : Initiator side of the E-stage multiply/divide handshake.
//                Forwards the decoded md op and operands to the HILO unit,
//                tracks the unit latency with a shadow countdown, stalls E
//                for md instructions that meet an operation in flight, and
//                raises a sticky flag if the shadow and the unit disagree.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int OP_W     = c_HILO_OP_W,
  parameter int MULT_LAT = c_MULT_LAT_DEF,
  parameter int DIV_LAT  = c_DIV_LAT_DEF,
  parameter int CNT_W    = 4
) (
  input  wire logic         Clk,
  input  wire logic         Rst,
  md_issue_ctrl_if.master   bus
);

  // --------------------------------------------------------------------------
  // Op-class decode helpers
  // --------------------------------------------------------------------------
  function automatic logic f_is_mul(input logic [OP_W-1:0] op);
    return (op == OP_W'(c_HILO_MULT)) || (op == OP_W'(c_HILO_MULTU));
  endfunction

  function automatic logic f_is_div(input logic [OP_W-1:0] op);
    return (op == OP_W'(c_HILO_DIV)) || (op == OP_W'(c_HILO_DIVU));
  endfunction

  function automatic logic f_is_start(input logic [OP_W-1:0] op);
    return f_is_mul(op) || f_is_div(op);
  endfunction

  function automatic logic f_is_access(input logic [OP_W-1:0] op);
    return (op == OP_W'(c_HILO_MFHI)) || (op == OP_W'(c_HILO_MFLO)) ||
           (op == OP_W'(c_HILO_MTHI)) || (op == OP_W'(c_HILO_MTLO));
  endfunction

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] c_DIV_CNT  = CNT_W'(DIV_LAT);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_remain;
  logic [CNT_W-1:0] w_remain_nxt;
  logic             r_err;
  logic             w_err_set;

  logic             w_e_start;
  logic             w_e_md;
  logic             w_stall;
  logic [OP_W-1:0]  w_mdu_op;

  // Classify E instruction, derive stall and the op actually sent to the unit.
  // Stall depends on current state only, so a start op meeting the final RUN
  // cycle is held one cycle and issues from IDLE on the next.
  always_comb begin
    w_e_start = f_is_start(bus.E_MdOp);
    w_e_md    = w_e_start | f_is_access(bus.E_MdOp);
    w_stall   = (r_state == ST_RUN) & bus.E_Valid & w_e_md;
    w_mdu_op  = '0;
    if (Rst && bus.E_Valid && !bus.Req && !w_stall) begin
      w_mdu_op = bus.E_MdOp;
    end
  end

  // State register and shadow countdown.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state  <= ST_IDLE;
      r_remain <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_remain <= w_remain_nxt;
    end
  end

  // Next-state logic; a flushed cycle (Req) is ignored by the unit, so the
  // shadow holds as well.
  always_comb begin
    w_state_nxt  = r_state;
    w_remain_nxt = r_remain;
    case (r_state)
      ST_IDLE: begin
        if (!bus.Req && bus.E_Valid && w_e_start) begin
          w_state_nxt  = ST_RUN;
          w_remain_nxt = f_is_div(bus.E_MdOp) ? c_DIV_CNT : c_MULT_CNT;
        end
      end
      ST_RUN: begin
        if (!bus.Req) begin
          if (r_remain == c_ONE) begin
            w_state_nxt  = ST_IDLE;
            w_remain_nxt = '0;
          end else begin
            w_remain_nxt = r_remain - c_ONE;
          end
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_remain_nxt = '0;
      end
    endcase
  end

  // Shadow/unit disagreement: unit idle while we count, or unit busy while
  // we are idle and nothing is being started this cycle.
  always_comb begin
    w_err_set = ((r_state == ST_RUN)  && !bus.Mdu_Busy) ||
                ((r_state == ST_IDLE) && !f_is_start(w_mdu_op) && bus.Mdu_Busy);
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.Mdu_Op  = w_mdu_op;
  assign bus.Mdu_D1  = bus.E_RsVal;
  assign bus.Mdu_D2  = bus.E_RtVal;
  assign bus.Stall_E = w_stall;
  assign bus.Pending = (r_state == ST_RUN);
  assign bus.Remain  = r_remain;
  assign bus.Err     = r_err;

endmodule : md_issue_ctrl
`default_nettype wire
